// File: rtl/sync_fifo_flags_if.sv
// Handshake and status bundle for sync_fifo_flags.
// master drives requests, slave is the FIFO.
interface sync_fifo_flags_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  valid_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, rd_en, din,
    input  dout, valid_out,
    input  full, empty,
    input  almost_full, almost_empty,
    input  count, overflow, underflow
  );

  modport slave (
    input  wr_en, rd_en, din,
    output dout, valid_out,
    output full, empty,
    output almost_full, almost_empty,
    output count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy flags, error pulses
// and selectable registered or first-word-fall-through read.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 1 << ADDR_WIDTH,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter bit FWFT       = 1'b0
) (
  input logic clk,
  input logic rst_n,
  sync_fifo_flags_if.slave f
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_LVL   = CW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  ovf_q;
  logic                  udf_q;

  assign full  = (count == FULL_LVL);
  assign empty = (count == '0);
  assign wr_ok = f.wr_en & ~full;
  assign rd_ok = f.rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= f.din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        wr_ok & ~rd_ok: count <= count + 1'b1;
        rd_ok & ~wr_ok: count <= count - 1'b1;
        default:        count <= count;
      endcase
      ovf_q <= f.wr_en & full;
      udf_q <= f.rd_en & empty;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is shown directly; zero while empty.
      assign f.dout      = empty ? '0 : mem[rd_ptr];
      assign f.valid_out = ~empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          if (rd_ok) dout_q <= mem[rd_ptr];
          valid_q <= rd_ok;
        end
      end

      assign f.dout      = dout_q;
      assign f.valid_out = valid_q;
    end
  endgenerate

  assign f.count        = count;
  assign f.full         = full;
  assign f.empty        = empty;
  assign f.almost_full  = (count >= AF_LVL);
  assign f.almost_empty = (count <= AE_LVL);
  assign f.overflow     = ovf_q;
  assign f.underflow    = udf_q;

endmodule

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 4, address width in bits.
REQ-003 Parameter DEPTH, default 1<<ADDR_WIDTH, number of entries; always a power of two.
REQ-004 Parameter AF_THRESH, default DEPTH-2, almost_full level; legal range 1..DEPTH.
REQ-005 Parameter AE_THRESH, default 2, almost_empty level; legal range 0..DEPTH-1.
REQ-006 Parameter FWFT, default 0, 0 = standard registered read, 1 = first-word-fall-through.
REQ-007 One clock; reset is asynchronous and active-low.
REQ-008 clk  input  1  sole clock; all state updates on its rising edge.
REQ-009 rst_n  input  1  asynchronous active-low reset.
REQ-010 wr_en  input  1  write request.
REQ-011 rd_en  input  1  read request (pop).
REQ-012 din  input  DATA_WIDTH  write data.
REQ-013 dout  output  DATA_WIDTH  read data.
REQ-014 valid_out  output  1  dout holds valid read data.
REQ-015 full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-016 count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-017 overflow, underflow  output  1 each  one-cycle error pulses.

Function
REQ-018 Storage: DEPTH x DATA_WIDTH array; binary read/write pointers of ADDR_WIDTH bits that wrap modulo DEPTH; storage is not reset.
REQ-019 Write is accepted iff wr_en=1 and full=0; an accepted write stores din at wr_ptr and increments wr_ptr.
REQ-020 Read is accepted iff rd_en=1 and empty=0; an accepted read increments rd_ptr.
REQ-021 count is registered: +1 on write-only, -1 on read-only, unchanged when both or neither are accepted.
REQ-022 Both accepted in the same cycle (0<count<DEPTH): both pointers advance and count holds.
REQ-023 When full, a write is rejected even if a read is accepted in the same cycle; the read proceeds and the write raises overflow.
REQ-024 When empty, a read is rejected even if a write is accepted in the same cycle; the write proceeds and the read raises underflow.
REQ-025 Flags are decoded from registered count: full = (count==DEPTH); empty = (count==0); almost_full = (count>=AF_THRESH); almost_empty = (count<=AE_THRESH).
REQ-026 overflow is a registered pulse, high for exactly one cycle after each rejected write; underflow is the same for each rejected read.
REQ-027 FWFT=0: dout is registered and updates to mem[rd_ptr] one cycle after an accepted read, otherwise holds; valid_out=1 for exactly that one cycle and only for accepted reads.
REQ-028 FWFT=1: dout = mem[rd_ptr] combinationally whenever empty=0; valid_out = ~empty; an accepted rd_en pops the word, and the next word (or empty) is visible the following cycle.
REQ-029 Write-to-empty latency: empty deasserts one cycle after the accepted write; with FWFT=1 the word appears on dout in that same cycle.
REQ-030 Pointer wrap: correct data order across any number of wraps, including at the DEPTH-1 -> 0 boundary.

Reset
REQ-031 While rst_n=0, and immediately on its assertion regardless of clk: pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, valid_out=0, dout=0.
REQ-032 Reset mid-operation discards all contents; the first accepted read after reset returns the first word written after reset.
REQ-033 Requests presented in the first clock edge after rst_n deasserts are processed normally.

Verification
REQ-034 Fill/drain (DEPTH=16, FWFT=0): write 0x00..0x0F -> full=1 and count=16 after the 16th write; then 16 reads -> dout 0x00..0x0F in order with valid_out per read, and empty=1 at the end.
REQ-035 Overflow/underflow: 17th write while full -> overflow pulses for 1 cycle and contents unchanged; read while empty -> underflow pulses for 1 cycle and valid_out=0.
REQ-036 Simultaneous: at count=8, wr_en=rd_en=1 for 20 cycles -> count stays 8 and output order matches write order across the pointer wrap.
REQ-037 Thresholds (AF=14, AE=2): almost_full rises when count reaches 14; almost_empty falls when count reaches 3 and rises again at count 2.
REQ-038 FWFT=1: write 0xA5 into empty FIFO -> next cycle dout=0xA5 and valid_out=1 with no rd_en; rd_en=1 -> empty=1 and valid_out=0 the following cycle.
REQ-039 Reset mid-stream: at count=5, assert rst_n=0 between clock edges -> all outputs reach their reset values immediately; after release, write 0x3C then read -> dout=0x3C.
